// File: rtl/mac_stream_cmp_pkg.sv
// Shared types, defaults and helpers for the TX-vs-RX MAC payload checker.
package mac_stream_cmp_pkg;

  localparam logic [15:0] IDLE_PAT0_DEF = 16'hdf1c;
  localparam logic [15:0] IDLE_PAT1_DEF = 16'h2144;

  typedef logic [1:0] state_t;
  localparam state_t ST_HUNT   = 2'd0;
  localparam state_t ST_LOCK   = 2'd1;
  localparam state_t ST_BYPASS = 2'd2;

  // Increment that sticks at 2**w-1 instead of wrapping (w <= 63).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/mac_stream_cmp_sc_if.sv
// Stream inputs and status outputs of the payload checker, bundled as one port.
interface mac_stream_cmp_sc_if #(
  parameter int unsigned LANE_W = 16,
  parameter int unsigned PACK   = 4,
  parameter int unsigned CNT_W  = 32
) ();
  localparam int unsigned W = LANE_W * PACK;

  logic              tx_valid;
  logic              tx_ready;
  logic [LANE_W-1:0] tx_data;
  logic              rx_valid;
  logic [LANE_W-1:0] rx_data;

  logic              locked;
  logic [1:0]        state;
  logic [CNT_W-1:0]  tx_wr_count;
  logic [CNT_W-1:0]  rx_wr_count;
  logic [CNT_W-1:0]  cmp_count;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  drop_count;
  logic              err_pulse;
  logic              err_sticky;
  logic [W-1:0]      first_err_tx;
  logic [W-1:0]      first_err_rx;
  logic              tx_overflow;
  logic              rx_overflow;

  modport master (
    output tx_valid, tx_ready, tx_data, rx_valid, rx_data,
    input  locked, state, tx_wr_count, rx_wr_count, cmp_count, err_count, drop_count,
           err_pulse, err_sticky, first_err_tx, first_err_rx, tx_overflow, rx_overflow
  );

  modport slave (
    input  tx_valid, tx_ready, tx_data, rx_valid, rx_data,
    output locked, state, tx_wr_count, rx_wr_count, cmp_count, err_count, drop_count,
           err_pulse, err_sticky, first_err_tx, first_err_rx, tx_overflow, rx_overflow
  );
endinterface

// File: rtl/mac_cmp_sync_fifo.sv
// First-word-fall-through synchronous FIFO with one-bit-extended pointers.
module mac_cmp_sync_fifo #(
  parameter int unsigned W  = 64,
  parameter int unsigned AW = 6
) (
  input  logic         clk,
  input  logic         flush_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_c,
  output logic         full_c,
  output logic         empty_c
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PW    = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic          do_wr, do_rd;

  assign empty_c   = (wptr_q == rptr_q);
  assign full_c    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data_c = mem_q[rptr_q[AW-1:0]];
  assign do_wr     = wr_en_i && !full_c;
  assign do_rd     = rd_en_i && !empty_c;

  always_ff @(posedge clk) begin
    if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + PW'(1);
      if (do_rd) rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage needs no reset; pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (do_wr && !flush_i) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule

// File: rtl/mac_stream_cmp_sc.sv
// TX-vs-RX payload checker: idle filter, lane packer, dual FIFO, hunt/lock compare and status.
module mac_stream_cmp_sc
  import mac_stream_cmp_pkg::*;
#(
  parameter int unsigned       LANE_W    = 16,
  parameter int unsigned       PACK      = 4,
  parameter int unsigned       FIFO_AW   = 6,
  parameter logic [LANE_W-1:0] IDLE_PAT0 = LANE_W'(IDLE_PAT0_DEF),
  parameter logic [LANE_W-1:0] IDLE_PAT1 = LANE_W'(IDLE_PAT1_DEF),
  parameter int unsigned       CNT_W     = 32,
  parameter bit                ALIGN_EN  = 1'b1,
  parameter int unsigned       LOSS_THR  = 4
) (
  input logic          mon_clk,
  input logic          mon_rst,
  input logic          clear,
  mac_stream_cmp_sc_if.slave bus
);
  localparam int unsigned W       = LANE_W * PACK;
  localparam int unsigned LANE_CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned MISS_W  = $clog2(LOSS_THR + 1);
  localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(PACK - 1);
  localparam state_t RESET_ST = ALIGN_EN ? ST_HUNT : ST_BYPASS;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), CNT_W));
  endfunction

  logic flush_c;
  assign flush_c = mon_rst | clear;

  // Stage 1: plain input registers (index 0 = TX, 1 = RX).
  logic [1:0]        in_v_q;
  logic [LANE_W-1:0] in_d_q [2];

  always_ff @(posedge mon_clk) begin
    if (flush_c) begin
      in_v_q    <= '0;
      in_d_q[0] <= '0;
      in_d_q[1] <= '0;
    end else begin
      in_v_q    <= {bus.rx_valid, bus.tx_valid & bus.tx_ready};
      in_d_q[0] <= bus.tx_data;
      in_d_q[1] <= bus.rx_data;
    end
  end

  // Stage 2: drop idle lanes and pack accepted lanes LSB-first into words.
  logic [W-1:0]       acc_q [2], acc_d [2], word_q [2], word_d [2];
  logic [LANE_CW-1:0] lane_q [2], lane_d [2];
  logic [1:0]         word_vld_q, word_vld_d;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      acc_d[s]      = acc_q[s];
      lane_d[s]     = lane_q[s];
      word_d[s]     = word_q[s];
      word_vld_d[s] = 1'b0;
      if (in_v_q[s] && in_d_q[s] != IDLE_PAT0 && in_d_q[s] != IDLE_PAT1) begin
        acc_d[s][LANE_W*int'(lane_q[s]) +: LANE_W] = in_d_q[s];
        if (lane_q[s] == LAST_LANE) begin
          lane_d[s]     = '0;
          word_d[s]     = acc_d[s];
          word_vld_d[s] = 1'b1;
        end else begin
          lane_d[s] = lane_q[s] + LANE_CW'(1);
        end
      end
    end
  end

  always_ff @(posedge mon_clk) begin
    if (flush_c) begin
      for (int s = 0; s < 2; s++) begin
        acc_q[s]  <= '0;
        word_q[s] <= '0;
        lane_q[s] <= '0;
      end
      word_vld_q <= '0;
    end else begin
      acc_q      <= acc_d;
      word_q     <= word_d;
      lane_q     <= lane_d;
      word_vld_q <= word_vld_d;
    end
  end

  logic [W-1:0] tx_head_c, rx_head_c;
  logic         tx_full_c, rx_full_c, tx_empty_c, rx_empty_c;
  logic         pop_tx_c, pop_rx_c, mis_c;

  mac_cmp_sync_fifo #(.W(W), .AW(FIFO_AW)) u_tx_fifo (
    .clk(mon_clk), .flush_i(flush_c), .wr_en_i(word_vld_q[0]), .wr_data_i(word_q[0]),
    .rd_en_i(pop_tx_c), .rd_data_c(tx_head_c), .full_c(tx_full_c), .empty_c(tx_empty_c)
  );

  mac_cmp_sync_fifo #(.W(W), .AW(FIFO_AW)) u_rx_fifo (
    .clk(mon_clk), .flush_i(flush_c), .wr_en_i(word_vld_q[1]), .wr_data_i(word_q[1]),
    .rd_en_i(pop_rx_c), .rd_data_c(rx_head_c), .full_c(rx_full_c), .empty_c(rx_empty_c)
  );

  assign mis_c = (tx_head_c != rx_head_c);

  state_t             state_q, state_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [CNT_W-1:0]   txw_q, txw_d, rxw_q, rxw_d, cmp_q, cmp_d, err_q, err_d, drop_q, drop_d;
  logic               pulse_q, pulse_d, sticky_q, sticky_d, locked_q, locked_d;
  logic               txovf_q, txovf_d, rxovf_q, rxovf_d;
  logic [W-1:0]       ftx_q, ftx_d, frx_q, frx_d;

  // Compare FSM: pops happen only when both heads are present.
  always_comb begin
    state_d  = state_q;
    miss_d   = miss_q;
    cmp_d    = cmp_q;
    err_d    = err_q;
    drop_d   = drop_q;
    sticky_d = sticky_q;
    ftx_d    = ftx_q;
    frx_d    = frx_q;
    pulse_d  = 1'b0;
    pop_tx_c = 1'b0;
    pop_rx_c = 1'b0;
    txw_d    = word_vld_q[0] ? inc(txw_q) : txw_q;
    rxw_d    = word_vld_q[1] ? inc(rxw_q) : rxw_q;
    txovf_d  = txovf_q | (word_vld_q[0] & tx_full_c);
    rxovf_d  = rxovf_q | (word_vld_q[1] & rx_full_c);

    if (!tx_empty_c && !rx_empty_c) begin
      case (state_q)
        ST_HUNT: begin
          pop_rx_c = 1'b1;
          if (!mis_c) begin
            pop_tx_c = 1'b1;
            state_d  = ST_LOCK;
            cmp_d    = inc(cmp_q);
            miss_d   = '0;
          end else begin
            drop_d = inc(drop_q);
          end
        end
        ST_LOCK, ST_BYPASS: begin
          pop_tx_c = 1'b1;
          pop_rx_c = 1'b1;
          cmp_d    = inc(cmp_q);
          if (mis_c) begin
            err_d    = inc(err_q);
            pulse_d  = 1'b1;
            sticky_d = 1'b1;
            if (!sticky_q) begin
              ftx_d = tx_head_c;
              frx_d = rx_head_c;
            end
            if (state_q == ST_LOCK) begin
              if (32'(miss_q) + 32'd1 >= LOSS_THR) begin
                state_d = ST_HUNT;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + MISS_W'(1);
              end
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = RESET_ST;
      endcase
    end
    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge mon_clk) begin
    if (flush_c) begin
      state_q  <= RESET_ST;
      miss_q   <= '0;
      txw_q    <= '0;
      rxw_q    <= '0;
      cmp_q    <= '0;
      err_q    <= '0;
      drop_q   <= '0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      locked_q <= 1'b0;
      txovf_q  <= 1'b0;
      rxovf_q  <= 1'b0;
      ftx_q    <= '0;
      frx_q    <= '0;
    end else begin
      state_q  <= state_d;
      miss_q   <= miss_d;
      txw_q    <= txw_d;
      rxw_q    <= rxw_d;
      cmp_q    <= cmp_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      locked_q <= locked_d;
      txovf_q  <= txovf_d;
      rxovf_q  <= rxovf_d;
      ftx_q    <= ftx_d;
      frx_q    <= frx_d;
    end
  end

  assign bus.locked       = locked_q;
  assign bus.state        = state_q;
  assign bus.tx_wr_count  = txw_q;
  assign bus.rx_wr_count  = rxw_q;
  assign bus.cmp_count    = cmp_q;
  assign bus.err_count    = err_q;
  assign bus.drop_count   = drop_q;
  assign bus.err_pulse    = pulse_q;
  assign bus.err_sticky   = sticky_q;
  assign bus.first_err_tx = ftx_q;
  assign bus.first_err_rx = frx_q;
  assign bus.tx_overflow  = txovf_q;
  assign bus.rx_overflow  = rxovf_q;
endmodule

// File: tb/tb_mac_stream_cmp_sc.sv
// Bench for mac_stream_cmp_sc: random lane streams against a queue-based word model.
module tb_mac_stream_cmp_sc;
  logic mon_clk = 1'b0;
  logic mon_rst = 1'b1;
  logic clear_a = 1'b0;
  logic clear_b = 1'b0;

  always #5 mon_clk = ~mon_clk;

  mac_stream_cmp_sc_if #(.LANE_W(16), .PACK(4), .CNT_W(32)) ifa ();
  mac_stream_cmp_sc_if #(.LANE_W(16), .PACK(4), .CNT_W(4))  ifb ();

  mac_stream_cmp_sc #(.LANE_W(16), .PACK(4), .FIFO_AW(6), .CNT_W(32), .ALIGN_EN(1'b1), .LOSS_THR(4))
    dut_a (.mon_clk(mon_clk), .mon_rst(mon_rst), .clear(clear_a), .bus(ifa));
  mac_stream_cmp_sc #(.LANE_W(16), .PACK(4), .FIFO_AW(6), .CNT_W(4), .ALIGN_EN(1'b0), .LOSS_THR(4))
    dut_b (.mon_clk(mon_clk), .mon_rst(mon_rst), .clear(clear_b), .bus(ifb));

  int n_checks = 0;
  int n_err    = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always @(posedge mon_clk) begin
    if (ifa.err_pulse === 1'b1) pulses_a++;
    if (ifb.err_pulse === 1'b1) pulses_b++;
  end

  // Word-level reference state
  logic [15:0]     txl[$], rxl[$];
  logic [63:0]     mq_tx[$], mq_rx[$];
  logic [63:0]     m_part [2];
  int              m_n [2];
  int              m_state, m_miss, e_pulses, pulse_base;
  longint unsigned m_max, e_cmp, e_err, e_drop, e_txw, e_rxw;
  bit              e_sticky, e_txovf, e_rxovf;
  logic [63:0]     e_ftx, e_frx;

  function automatic longint unsigned sinc(input longint unsigned v);
    return (v >= m_max) ? m_max : v + 1;
  endfunction

  function automatic logic [15:0] rand_lane();
    logic [15:0] v;
    v = 16'($urandom);
    while (v == 16'hdf1c || v == 16'h2144 || v == 16'hde1c || v == 16'h2044) v = 16'($urandom);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input bit align, input int cntw, input int tgt);
    txl.delete(); rxl.delete(); mq_tx.delete(); mq_rx.delete();
    for (int s = 0; s < 2; s++) begin m_part[s] = '0; m_n[s] = 0; end
    m_state = align ? 0 : 2;
    m_miss = 0; e_pulses = 0;
    m_max = (64'd1 << cntw) - 64'd1;
    e_cmp = 0; e_err = 0; e_drop = 0; e_txw = 0; e_rxw = 0;
    e_sticky = 0; e_txovf = 0; e_rxovf = 0; e_ftx = '0; e_frx = '0;
    pulse_base = (tgt == 0) ? pulses_a : pulses_b;
  endtask

  task automatic model_lane(input int s, input logic [15:0] v);
    if (v == 16'hdf1c || v == 16'h2144) return;
    m_part[s][16*m_n[s] +: 16] = v;
    m_n[s]++;
    if (m_n[s] == 4) begin
      if (s == 0) begin mq_tx.push_back(m_part[0]); e_txw = sinc(e_txw); end
      else        begin mq_rx.push_back(m_part[1]); e_rxw = sinc(e_rxw); end
      m_n[s] = 0;
    end
  endtask

  // Pairs words in arrival order: hunt discards RX until heads agree, lock counts misses.
  task automatic model_cmp();
    logic [63:0] t, r;
    while (mq_tx.size() > 0 && mq_rx.size() > 0) begin
      t = mq_tx[0];
      r = mq_rx[0];
      if (m_state == 0 && t != r) begin
        void'(mq_rx.pop_front());
        e_drop = sinc(e_drop);
      end else begin
        void'(mq_tx.pop_front());
        void'(mq_rx.pop_front());
        e_cmp = sinc(e_cmp);
        if (m_state == 0) begin
          m_state = 1;
          m_miss  = 0;
        end else if (t != r) begin
          e_err = sinc(e_err);
          e_pulses++;
          if (!e_sticky) begin e_ftx = t; e_frx = r; end
          e_sticky = 1;
          if (m_state == 1) begin
            m_miss++;
            if (m_miss == 4) begin m_state = 0; m_miss = 0; end
          end
        end else begin
          m_miss = 0;
        end
      end
    end
  endtask

  task automatic set_in(input int tgt, input bit tv, input bit tr, input logic [15:0] td,
                        input bit rv, input logic [15:0] rd);
    if (tgt == 0) begin
      ifa.tx_valid = tv; ifa.tx_ready = tr; ifa.tx_data = td; ifa.rx_valid = rv; ifa.rx_data = rd;
    end else begin
      ifb.tx_valid = tv; ifb.tx_ready = tr; ifb.tx_data = td; ifb.rx_valid = rv; ifb.rx_data = rd;
    end
  endtask

  task automatic drive(input int tgt);
    bit tv, tr, rv;
    int guard = 0;
    while ((txl.size() > 0 || rxl.size() > 0) && guard < 20000) begin
      @(posedge mon_clk); #1;
      tv = (txl.size() > 0) && ($urandom_range(3) != 0);
      tr = ($urandom_range(3) != 0);
      rv = (rxl.size() > 0) && ($urandom_range(3) != 0);
      set_in(tgt, tv, tr, (txl.size() > 0) ? txl[0] : 16'h0, rv, (rxl.size() > 0) ? rxl[0] : 16'h0);
      if (tv && tr) model_lane(0, txl.pop_front());
      if (rv)       model_lane(1, rxl.pop_front());
      guard++;
    end
    @(posedge mon_clk); #1;
    set_in(tgt, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (100) @(posedge mon_clk);
    #1;
  endtask

  task automatic gen_pair(input int n, input int lead, input int bad_lo, input int bad_hi);
    logic [15:0] v;
    for (int i = 0; i < lead; i++)
      for (int j = 0; j < 4; j++) rxl.push_back(rand_lane());
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        v = rand_lane();
        if ($urandom_range(7) == 0) txl.push_back(16'hdf1c);
        txl.push_back(v);
        if ($urandom_range(7) == 0) rxl.push_back(16'h2144);
        rxl.push_back((i >= bad_lo && i <= bad_hi && j == 0) ? (v ^ 16'h0100) : v);
      end
    end
  endtask

  task automatic check_all(input int tgt, input string nm);
    logic [63:0] o_cmp, o_err, o_drop, o_txw, o_rxw, o_st, o_lk, o_sk, o_ftx, o_frx, o_tov, o_rov;
    int o_p;
    model_cmp();
    if (tgt == 0) begin
      o_cmp = 64'(ifa.cmp_count);   o_err = 64'(ifa.err_count);     o_drop = 64'(ifa.drop_count);
      o_txw = 64'(ifa.tx_wr_count); o_rxw = 64'(ifa.rx_wr_count);   o_st   = 64'(ifa.state);
      o_lk  = 64'(ifa.locked);      o_sk  = 64'(ifa.err_sticky);    o_ftx  = ifa.first_err_tx;
      o_frx = ifa.first_err_rx;     o_tov = 64'(ifa.tx_overflow);   o_rov  = 64'(ifa.rx_overflow);
      o_p   = pulses_a - pulse_base;
    end else begin
      o_cmp = 64'(ifb.cmp_count);   o_err = 64'(ifb.err_count);     o_drop = 64'(ifb.drop_count);
      o_txw = 64'(ifb.tx_wr_count); o_rxw = 64'(ifb.rx_wr_count);   o_st   = 64'(ifb.state);
      o_lk  = 64'(ifb.locked);      o_sk  = 64'(ifb.err_sticky);    o_ftx  = ifb.first_err_tx;
      o_frx = ifb.first_err_rx;     o_tov = 64'(ifb.tx_overflow);   o_rov  = 64'(ifb.rx_overflow);
      o_p   = pulses_b - pulse_base;
    end
    check({nm, ".cmp_count"},    o_cmp, e_cmp);
    check({nm, ".err_count"},    o_err, e_err);
    check({nm, ".drop_count"},   o_drop, e_drop);
    check({nm, ".tx_wr_count"},  o_txw, e_txw);
    check({nm, ".rx_wr_count"},  o_rxw, e_rxw);
    check({nm, ".state"},        o_st, 64'(m_state));
    check({nm, ".locked"},       o_lk, 64'(m_state == 1));
    check({nm, ".err_sticky"},   o_sk, 64'(e_sticky));
    check({nm, ".first_err_tx"}, o_ftx, e_ftx);
    check({nm, ".first_err_rx"}, o_frx, e_frx);
    check({nm, ".tx_overflow"},  o_tov, 64'(e_txovf));
    check({nm, ".rx_overflow"},  o_rov, 64'(e_rxovf));
    check({nm, ".pulses"},       64'(o_p), 64'(e_pulses));
  endtask

  task automatic pulse_clear(input int tgt);
    @(posedge mon_clk); #1;
    if (tgt == 0) clear_a = 1'b1; else clear_b = 1'b1;
    @(posedge mon_clk); #1;
    clear_a = 1'b0;
    clear_b = 1'b0;
    repeat (2) @(posedge mon_clk);
    #1;
  endtask

  initial begin
    set_in(0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    set_in(1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (3) @(posedge mon_clk);
    #1 mon_rst = 1'b0;
    repeat (2) @(posedge mon_clk);
    #1;

    // Reset state of both instances
    model_reset(1'b1, 32, 0);
    check_all(0, "rst_a");
    model_reset(1'b0, 4, 1);
    check_all(1, "rst_b");

    // Idle lanes vanish before packing
    model_reset(1'b1, 32, 0);
    txl = '{16'h0001, 16'hdf1c, 16'h0002, 16'h2144, 16'h0003, 16'h0004};
    rxl = txl;
    drive(0);
    check_all(0, "idle");
    check("idle.cmp_const", 64'(ifa.cmp_count), 64'd1);

    // Clear mid-word discards the partial TX word
    txl = '{16'h0009, 16'h000a};
    drive(0);
    pulse_clear(0);
    model_reset(1'b1, 32, 0);
    check_all(0, "clear");
    txl = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
    rxl = txl;
    drive(0);
    check_all(0, "post_clear");

    // RX leads by three words: hunt then lock
    pulse_clear(0);
    model_reset(1'b1, 32, 0);
    gen_pair(100, 3, -1, -1);
    drive(0);
    check_all(0, "realign");
    check("realign.drop_const", 64'(ifa.drop_count), 64'd3);

    // Four consecutive bad RX words knock the lock loose
    gen_pair(7, 0, 3, 6);
    drive(0);
    check_all(0, "loss");

    // TX only: 65 words into a 64-deep FIFO
    pulse_clear(0);
    model_reset(1'b1, 32, 0);
    for (int i = 0; i < 65 * 4; i++) txl.push_back(rand_lane());
    drive(0);
    e_txovf = 1'b1;
    check_all(0, "ovf");
    check("ovf.txw_const", 64'(ifa.tx_wr_count), 64'd65);

    // Four-bit counters saturate in bypass while pulses keep firing
    pulse_clear(1);
    model_reset(1'b0, 4, 1);
    gen_pair(20, 0, 0, 19);
    drive(1);
    check_all(1, "sat");
    check("sat.err_const", 64'(ifb.err_count), 64'd15);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
